// File: rtl/regsrc2_sequencer_if.sv
// Decoder <-> regsrc2 sequencer signal bundle.
// master = decoder/control side, slave = sequencer.
interface regsrc2_sequencer_if #(
    parameter int SEL_W = 3
);
    logic             start;
    logic [1:0]       op;
    logic             stall;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic             done;
    logic [1:0]       step;

    modport master (
        output start, op, stall,
        input  sel, sel_valid, busy, done, step
    );

    modport slave (
        input  start, op, stall,
        output sel, sel_valid, busy, done, step
    );
endinterface

// File: rtl/regsrc2_sequencer.sv
// Steps the register-source-2 operand mux code through short per-op code lists.
// state | meaning
// IDLE  | operand path selected, waiting for start
// RUN   | driving sequence code step_q of op_q
// DONE  | one-cycle completion pulse; start here relaunches immediately
module regsrc2_sequencer #(
    parameter int               SEL_W    = 3,
    parameter logic [SEL_W-1:0] IDLE_SEL = SEL_W'(4)
) (
    input  logic                 clk,
    input  logic                 rst,
    regsrc2_sequencer_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_SINGLE = 2'd0;
    localparam logic [1:0] OP_PUSH   = 2'd1;
    localparam logic [1:0] OP_TRAP   = 2'd2;
    localparam logic [1:0] OP_RET    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       step_q, step_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    function automatic logic [SEL_W-1:0] code_of(input logic [1:0] op, input logic [1:0] idx);
        logic [SEL_W-1:0] code;
        code = IDLE_SEL;
        case ({op, idx})
            {OP_SINGLE, 2'd0}: code = SEL_W'(4);
            {OP_PUSH,   2'd0}: code = SEL_W'(3);
            {OP_PUSH,   2'd1}: code = SEL_W'(0);
            {OP_TRAP,   2'd0}: code = SEL_W'(2);
            {OP_TRAP,   2'd1}: code = SEL_W'(1);
            {OP_TRAP,   2'd2}: code = SEL_W'(5);
            {OP_TRAP,   2'd3}: code = SEL_W'(3);
            {OP_RET,    2'd0}: code = SEL_W'(3);
            {OP_RET,    2'd1}: code = SEL_W'(4);
            default:           code = IDLE_SEL;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] last_step(input logic [1:0] op);
        logic [1:0] last;
        case (op)
            OP_SINGLE: last = 2'd0;
            OP_PUSH:   last = 2'd1;
            OP_TRAP:   last = 2'd3;
            default:   last = 2'd1;
        endcase
        return last;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start too, giving back-to-back macro-ops
                if (bus.start) begin
                    state_d = S_RUN;
                    op_d    = bus.op;
                    step_d  = 2'd0;
                    sel_d   = code_of(bus.op, 2'd0);
                end else begin
                    state_d = S_IDLE;
                    step_d  = 2'd0;
                    sel_d   = IDLE_SEL;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (step_q < last_step(op_q)) begin
                        step_d = step_q + 2'd1;
                        sel_d  = code_of(op_q, step_q + 2'd1);
                    end else begin
                        state_d = S_DONE;
                        step_d  = 2'd0;
                        sel_d   = IDLE_SEL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 2'd0;
                sel_d   = IDLE_SEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_SINGLE;
            step_q  <= 2'd0;
            sel_q   <= IDLE_SEL;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = (state_q == S_RUN);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.step      = step_q;
endmodule

// File: tb/tb_regsrc2_sequencer.sv
// Directed and random stimulus against a queue-based model of the code sequences.
module tb_regsrc2_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    regsrc2_sequencer_if #(.SEL_W(3)) bus ();

    regsrc2_sequencer #(.SEL_W(3), .IDLE_SEL(3'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    int seq_tab [4][4] = '{'{4, 0, 0, 0}, '{3, 0, 0, 0}, '{2, 1, 5, 3}, '{3, 4, 0, 0}};
    int seq_len [4]    = '{1, 2, 4, 2};

    // Model: remaining codes of the running macro-op, front is on the mux now.
    int m_q[$];
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_pos  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input int o, input bit st);
        if (r) begin
            m_run = 0; m_done = 0; m_q = {}; m_pos = 0;
        end else if (m_run) begin
            if (!st) begin
                void'(m_q.pop_front());
                m_pos++;
                if (m_q.size() == 0) begin
                    m_run = 0; m_done = 1; m_pos = 0;
                end
            end
        end else begin
            m_done = 0;
            if (s) begin
                m_q = {};
                for (int i = 0; i < seq_len[o]; i++) m_q.push_back(seq_tab[o][i]);
                m_pos = 0;
                m_run = 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input int o, input bit st);
        rst       = r;
        bus.start = s;
        bus.op    = o[1:0];
        bus.stall = st;
        @(posedge clk);
        model_edge(r, s, o, st);
        #1;
        chk("sel",       32'(bus.sel),       m_run ? m_q[0] : 4);
        chk("sel_valid", 32'(bus.sel_valid), 32'(m_run));
        chk("busy",      32'(bus.busy),      32'(m_run));
        chk("done",      32'(bus.done),      32'(m_done));
        chk("step",      32'(bus.step),      m_run ? m_pos : 0);
        if (bus.done === 1'b1) done_cnt++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.stall = 1'b0;

        // reset with start asserted
        cycle(1, 1, 2, 0);
        cycle(1, 1, 2, 0);

        // SINGLE
        cycle(0, 1, 0, 0);
        chk("single_t1_sel", 32'(bus.sel), 4);
        cycle(0, 0, 0, 0);
        chk("single_t2_done", 32'(bus.done), 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // TRAP with 3-cycle stall on step 1
        done_cnt = 0;
        cycle(0, 1, 2, 0);
        cycle(0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1);
        chk("trap_stall_step", 32'(bus.step), 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("trap_last_sel", 32'(bus.sel), 3);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("trap_done_pulses", 32'(done_cnt), 1);

        // PUSH then RET back-to-back; start during RUN ignored
        cycle(0, 1, 1, 0);
        cycle(0, 1, 2, 0);
        chk("push_ignore_start", 32'(bus.sel), 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 3, 0);
        chk("b2b_ret_first", 32'(bus.sel), 3);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // reset mid TRAP, then a full fresh TRAP
        done_cnt = 0;
        cycle(0, 1, 2, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("mid_reset_no_done", 32'(done_cnt), 0);
        cycle(0, 1, 2, 0);
        repeat (5) cycle(0, 0, 0, 0);

        // op change after acceptance
        cycle(0, 1, 1, 0);
        cycle(0, 0, 2, 0);
        chk("op_relatch_sel", 32'(bus.sel), 0);
        repeat (2) cycle(0, 0, 2, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regsrc2_sequencer.md
Name: regsrc2_sequencer

Overview:
- Micro-sequencer that drives the 3-bit selection code of the register-source-2 operand mux in the 16-bit single-cycle CPU.
- Single-step ops pass the decoded operand straight through.
- Multi-cycle macro-ops (PUSH, TRAP context save, RET) step the mux through a fixed code list, one code per accepted cycle.
- Sits between the instruction decoder and the mux; reports busy/done to the control unit so the PC can be held.

Parameters:
- SEL_W, 3, width of the mux selection code
- IDLE_SEL, 4, code driven while idle (code 4 = Input2, normal operand path)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request from decoder, sampled each rising edge
- op  input  2  macro-op kind, sampled only when start is accepted
- stall  input  1  pipeline hold; freezes current step
- sel  output  SEL_W  mux selection code (registered)
- sel_valid  output  1  high while sel carries a sequence step
- busy  output  1  high in RUN; decoder holds PC
- done  output  1  one-cycle pulse after the last step is accepted
- step  output  2  index of the current step within the sequence

Behaviour:
- Code meaning at the mux: 0 = Input1, 1 = const 2, 2 = const 4, 3 = const 15, 4 = Input2, 5 = const 3. Codes 6–7 are never driven.
- Sequences, indexed by op:
  - op 0 SINGLE: [4]
  - op 1 PUSH: [3, 0]
  - op 2 TRAP: [2, 1, 5, 3]
  - op 3 RET: [3, 4]
- Sequence length for each op is 1, 2, 4, 2 respectively. The op value is latched at acceptance; later changes to op are ignored.
- Reset (any cycle, including mid-sequence) returns to IDLE next edge: sel = IDLE_SEL, sel_valid = 0, busy = 0, done = 0, step = 0. Any in-flight sequence is discarded and produces no done pulse.
- States:
  - IDLE: outputs are the reset values. If start = 1 at edge t, state is RUN from t+1 with step = 0, sel = first code, sel_valid = 1, busy = 1.
  - RUN:
    - stall = 1 at an edge: all outputs hold.
    - stall = 0 and step < len-1: step increments and sel takes the next code.
    - stall = 0 and step = len-1: enter DONE.
    - start is ignored in RUN (no queueing).
  - DONE: lasts exactly one cycle. done = 1, busy = 0, sel_valid = 0, sel = IDLE_SEL, step = 0.
    - start = 1 in DONE is accepted: next state is RUN with the new op (back-to-back, no idle bubble).
    - Otherwise the next state is IDLE.
    - stall has no effect in DONE.
- Latency: start-to-first-code is 1 cycle. Unstalled total occupancy is len cycles in RUN plus 1 cycle in DONE.
- Simultaneous events:
  - rst has priority over start and stall.
  - stall on the final step delays DONE until stall drops.
- sel changes only on a clock edge (fully registered; no combinational path from start/op to sel).
- Illegal encoded state recovers to IDLE on the next edge.

Test Plan:
- Reset: rst = 1 for 2 cycles with start = 1, op = 2 -> sel = 4, sel_valid = 0, busy = 0, done = 0, step = 0 throughout.
- SINGLE: start = 1, op = 0 at t0 -> t1: sel = 4, sel_valid = 1, busy = 1, step = 0; t2: done = 1, busy = 0; t3: IDLE.
- TRAP with stall: start, op = 2, then stall = 1 during step 1 for 3 cycles -> sel sequence 2, 1, 1, 1, 1, 5, 3; step holds at 1 while stalled; done one cycle after the code-3 step; exactly one done pulse.
- Back-to-back: PUSH, then start, op = 3 asserted in the DONE cycle -> sel 3, 0, (DONE), 3, 4, (DONE) with no IDLE gap; start during RUN ignored (op not re-latched, sequence unchanged).
- Reset mid-op: start, op = 2; rst = 1 at step 2 -> next cycle sel = 4, busy = 0, no done pulse; a fresh start then runs the full 2, 1, 5, 3 from step 0.
- op change after acceptance: start, op = 1, then op = 2 on the next cycle -> sequence remains 3, 0 (PUSH).
